// File: rtl/ocp_rr_arbiter_if.sv
// Bus bundle between N OCP masters, the round-robin arbiter and the shared OCP slave.
// The arbiter uses the slave modport; the master modport drives both the master and slave sides.
interface ocp_rr_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
);
   logic [3*NUM_MASTERS-1:0]              m_MCmd;
   logic [ADDR_WIDTH*NUM_MASTERS-1:0]     m_MAddr;
   logic [DATA_WIDTH*NUM_MASTERS-1:0]     m_MData;
   logic [(DATA_WIDTH/8)*NUM_MASTERS-1:0] m_MByteEn;
   logic [NUM_MASTERS-1:0]                m_SCmdAccept;
   logic [2*NUM_MASTERS-1:0]              m_SResp;
   logic [DATA_WIDTH*NUM_MASTERS-1:0]     m_SData;

   logic [2:0]                            s_MCmd;
   logic [ADDR_WIDTH-1:0]                 s_MAddr;
   logic [DATA_WIDTH-1:0]                 s_MData;
   logic [DATA_WIDTH/8-1:0]               s_MByteEn;
   logic                                  s_SCmdAccept;
   logic [1:0]                            s_SResp;
   logic [DATA_WIDTH-1:0]                 s_SData;

   modport slave (
      input  m_MCmd, m_MAddr, m_MData, m_MByteEn,
      input  s_SCmdAccept, s_SResp, s_SData,
      output m_SCmdAccept, m_SResp, m_SData,
      output s_MCmd, s_MAddr, s_MData, s_MByteEn
   );

   modport master (
      output m_MCmd, m_MAddr, m_MData, m_MByteEn,
      output s_SCmdAccept, s_SResp, s_SData,
      input  m_SCmdAccept, m_SResp, m_SData,
      input  s_MCmd, s_MAddr, s_MData, s_MByteEn
   );
endinterface

// File: rtl/ocp_rr_arbiter.sv
// N-master to 1-slave OCP arbiter: round-robin command grant plus an in-order FIFO
// that routes each non-posted response back to the master that issued it.
//
// state | meaning
// ARB   | scan eligible masters from rr_ptr+1, register the winner as grant
// BUSY  | granted command presented to the slave until s_SCmdAccept
module ocp_rr_arbiter #(
   parameter int NUM_MASTERS     = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   ocp_rr_arbiter_if.slave                    bus,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               err_unexpected
);
   localparam int BW = DATA_WIDTH / 8;
   localparam int GW = $clog2(NUM_MASTERS);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   localparam logic [2:0] CMD_IDLE = 3'd0;
   localparam logic [2:0] CMD_RD   = 3'd2;
   localparam logic [2:0] CMD_RDEX = 3'd3;
   localparam logic [2:0] CMD_RDL  = 3'd4;
   localparam logic [2:0] CMD_WRNP = 3'd5;
   localparam logic [2:0] CMD_WRC  = 3'd6;
   localparam logic [1:0] RESP_NULL = 2'd0;

   typedef enum logic {ARB, BUSY} state_t;

   state_t              state, state_nxt;
   logic [GW-1:0]       grant, grant_nxt;
   logic [GW-1:0]       rr_ptr, rr_ptr_nxt;
   logic [GW-1:0]       fifo_mem [MAX_OUTSTANDING];
   logic [PW-1:0]       head, tail;
   logic [CW-1:0]       count;
   logic [NUM_MASTERS-1:0] elig;
   logic                fifo_full, fifo_empty;
   logic                push, pop, resp_valid, found;
   logic [2:0]          gnt_cmd;
   logic [GW-1:0]       head_m;

   function automatic logic is_nonposted(input logic [2:0] c);
      return (c == CMD_RD) || (c == CMD_RDEX) || (c == CMD_RDL) ||
             (c == CMD_WRNP) || (c == CMD_WRC);
   endfunction

   function automatic int rr_idx(input int p, input int k);
      int s;
      s = p + k;
      if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
      return s;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full   = (count == CW'(MAX_OUTSTANDING));
   assign fifo_empty  = (count == '0);
   assign resp_valid  = (bus.s_SResp != RESP_NULL);
   assign pop         = resp_valid && !fifo_empty;
   assign gnt_cmd     = bus.m_MCmd[3*int'(grant) +: 3];
   assign head_m      = fifo_mem[head];
   assign outstanding = count;

   // Non-posted requests are held back while the FIFO has no room for their response slot.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         elig[i] = (bus.m_MCmd[3*i +: 3] != CMD_IDLE) &&
                   (!is_nonposted(bus.m_MCmd[3*i +: 3]) || !fifo_full);
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      push       = 1'b0;
      found      = 1'b0;
      case (state)
         ARB: begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
               if (!found && elig[rr_idx(int'(rr_ptr), k)]) begin
                  found     = 1'b1;
                  grant_nxt = GW'(rr_idx(int'(rr_ptr), k));
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (bus.s_SCmdAccept) begin
               rr_ptr_nxt = grant;
               push       = is_nonposted(gnt_cmd);
               state_nxt  = ARB;
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   // Accept and response routing are masked during reset so an abandoned grant never completes.
   always_comb begin
      bus.s_MCmd       = CMD_IDLE;
      bus.s_MAddr      = '0;
      bus.s_MData      = '0;
      bus.s_MByteEn    = '0;
      bus.m_SCmdAccept = '0;
      bus.m_SResp      = '0;
      bus.m_SData      = '0;
      if (state == BUSY) begin
         bus.s_MCmd    = gnt_cmd;
         bus.s_MAddr   = bus.m_MAddr[ADDR_WIDTH*int'(grant) +: ADDR_WIDTH];
         bus.s_MData   = bus.m_MData[DATA_WIDTH*int'(grant) +: DATA_WIDTH];
         bus.s_MByteEn = bus.m_MByteEn[BW*int'(grant) +: BW];
         if (!reset) bus.m_SCmdAccept[grant] = bus.s_SCmdAccept;
      end
      if (pop && !reset) begin
         bus.m_SResp[2*int'(head_m) +: 2]                 = bus.s_SResp;
         bus.m_SData[DATA_WIDTH*int'(head_m) +: DATA_WIDTH] = bus.s_SData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ARB;
         grant          <= '0;
         rr_ptr         <= GW'(NUM_MASTERS - 1);
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         err_unexpected <= 1'b0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (resp_valid && fifo_empty) err_unexpected <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) fifo_mem[tail] <= grant;
   end
endmodule

// File: tb/tb_ocp_rr_arbiter.sv
// Directed bench for ocp_rr_arbiter (4 masters, 2 outstanding): grant order, FIFO
// back-pressure and in-order response routing checked against a response scoreboard.
module tb_ocp_rr_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 2;

   localparam logic [2:0] C_IDLE = 3'd0;
   localparam logic [2:0] C_WR   = 3'd1;
   localparam logic [2:0] C_RD   = 3'd2;
   localparam logic [1:0] R_NULL = 2'd0;
   localparam logic [1:0] R_DVA  = 2'd1;
   localparam logic [1:0] R_FL   = 2'd2;
   localparam logic [1:0] R_ERR  = 2'd3;

   typedef struct {
      int          m;
      logic [1:0]  r;
      logic [31:0] d;
   } resp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] outstanding;
   logic       err_unexpected;

   resp_t resp_q[$];
   int    grant_q[$];
   int    n_cmp = 0;
   int    n_mis = 0;

   ocp_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ocp_rr_arbiter #(
      .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .outstanding    (outstanding),
      .err_unexpected (err_unexpected)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int m, input logic [2:0] cmd, input logic [31:0] addr);
      bus.m_MCmd[3*m +: 3]     = cmd;
      bus.m_MAddr[AW*m +: AW]  = addr;
      bus.m_MData[DW*m +: DW]  = addr ^ 32'hA5A5_A5A5;
      bus.m_MByteEn[4*m +: 4]  = 4'hF;
   endtask

   task automatic clear_all();
      bus.m_MCmd       = '0;
      bus.m_MAddr      = '0;
      bus.m_MData      = '0;
      bus.m_MByteEn    = '0;
      bus.s_SCmdAccept = 1'b0;
      bus.s_SResp      = R_NULL;
      bus.s_SData      = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_all();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // m < 0 marks a response that no master should see.
   task automatic respond(input logic [1:0] r, input logic [31:0] d, input int m);
      resp_t               e;
      logic [2*N-1:0]      exp_r;
      logic [DW*N-1:0]     exp_d;
      resp_q.push_back('{m, r, d});
      bus.s_SResp = r;
      bus.s_SData = d;
      #1;
      e     = resp_q.pop_front();
      exp_r = '0;
      exp_d = '0;
      if (e.m >= 0) begin
         exp_r[2*e.m +: 2]   = e.r;
         exp_d[DW*e.m +: DW] = e.d;
      end
      chk("resp_route", bus.m_SResp, exp_r);
      chk("data_route", bus.m_SData, exp_d);
      tick();
      bus.s_SResp = R_NULL;
      bus.s_SData = '0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;

      // reset state and single read round trip
      do_reset();
      #1;
      chk("rst_s_MCmd", bus.s_MCmd, C_IDLE);
      chk("rst_s_MAddr", bus.s_MAddr, 0);
      chk("rst_accept", bus.m_SCmdAccept, 0);
      chk("rst_m_SResp", bus.m_SResp, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_unexpected, 0);
      set_req(0, C_RD, 32'h100);
      #1;
      chk("t1_arb_idle", bus.s_MCmd, C_IDLE);
      tick(); #1;
      chk("t1_cmd", bus.s_MCmd, C_RD);
      chk("t1_addr", bus.s_MAddr, 32'h100);
      chk("t1_no_accept", bus.m_SCmdAccept, 0);
      bus.s_SCmdAccept = 1'b1;
      #1;
      chk("t1_accept", bus.m_SCmdAccept, 4'b0001);
      tick();
      set_req(0, C_IDLE, 32'h0);
      #1;
      chk("t1_outstanding1", outstanding, 1);
      respond(R_DVA, 32'hDEAD_BEEF, 0);
      chk("t1_outstanding0", outstanding, 0);

      // all masters posting writes: strict rotation with one bubble per grant
      do_reset();
      bus.s_SCmdAccept = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, C_WR, 32'h1000 + i);
      for (int k = 0; k < 8; k++) grant_q.push_back(k % N);
      for (int k = 0; k < 8; k++) begin
         tick(); #1;
         g = grant_q.pop_front();
         chk("t2_cmd", bus.s_MCmd, C_WR);
         chk("t2_accept", bus.m_SCmdAccept, 1 << g);
         chk("t2_addr", bus.s_MAddr, 32'h1000 + g);
         chk("t2_data", bus.s_MData, (32'h1000 + g) ^ 32'hA5A5_A5A5);
         tick(); #1;
         chk("t2_bubble", bus.s_MCmd, C_IDLE);
      end
      for (int i = 0; i < N; i++) set_req(i, C_IDLE, 32'h0);
      chk("t2_outstanding", outstanding, 0);

      // FIFO full blocks master 1 reads while master 2 write proceeds
      do_reset();
      bus.s_SCmdAccept = 1'b1;
      set_req(1, C_RD, 32'h200);
      tick(); #1;
      chk("t3_rd0_accept", bus.m_SCmdAccept, 4'b0010);
      chk("t3_rd0_addr", bus.s_MAddr, 32'h200);
      tick();
      set_req(1, C_RD, 32'h204);
      #1;
      chk("t3_out1", outstanding, 1);
      tick(); #1;
      chk("t3_rd1_accept", bus.m_SCmdAccept, 4'b0010);
      chk("t3_rd1_addr", bus.s_MAddr, 32'h204);
      tick();
      set_req(1, C_RD, 32'h208);
      set_req(2, C_WR, 32'h300);
      #1;
      chk("t3_out2", outstanding, 2);
      tick(); #1;
      chk("t3_wr_cmd", bus.s_MCmd, C_WR);
      chk("t3_wr_accept", bus.m_SCmdAccept, 4'b0100);
      chk("t3_wr_addr", bus.s_MAddr, 32'h300);
      tick();
      set_req(2, C_IDLE, 32'h0);
      #1;
      chk("t3_out2_after_wr", outstanding, 2);
      tick(); #1;
      chk("t3_full_block", bus.s_MCmd, C_IDLE);
      respond(R_DVA, 32'h11, 1);
      chk("t3_out_after_pop", outstanding, 1);
      tick(); #1;
      chk("t3_rd2_accept", bus.m_SCmdAccept, 4'b0010);
      chk("t3_rd2_addr", bus.s_MAddr, 32'h208);
      tick();
      set_req(1, C_IDLE, 32'h0);
      #1;
      chk("t3_out2_again", outstanding, 2);
      respond(R_DVA, 32'h22, 1);
      respond(R_DVA, 32'h33, 1);
      chk("t3_drained", outstanding, 0);

      // interleaved masters 0/3, responses ERR, DVA, FAIL in issue order
      do_reset();
      bus.s_SCmdAccept = 1'b1;
      set_req(0, C_RD, 32'h400);
      set_req(3, C_RD, 32'h430);
      tick(); #1;
      chk("t4_g0_accept", bus.m_SCmdAccept, 4'b0001);
      chk("t4_g0_addr", bus.s_MAddr, 32'h400);
      tick();
      set_req(0, C_RD, 32'h404);
      tick(); #1;
      chk("t4_g3_accept", bus.m_SCmdAccept, 4'b1000);
      chk("t4_g3_addr", bus.s_MAddr, 32'h430);
      tick();
      set_req(3, C_IDLE, 32'h0);
      #1;
      chk("t4_out2", outstanding, 2);
      respond(R_ERR, 32'hE0, 0);
      tick(); #1;
      chk("t4_g0b_accept", bus.m_SCmdAccept, 4'b0001);
      chk("t4_g0b_addr", bus.s_MAddr, 32'h404);
      tick();
      set_req(0, C_IDLE, 32'h0);
      #1;
      respond(R_DVA, 32'hD3, 3);
      respond(R_FL, 32'hF0, 0);
      chk("t4_drained", outstanding, 0);

      // unexpected response is dropped and flagged until reset
      respond(R_DVA, 32'h55, -1);
      chk("t5_err_set", err_unexpected, 1);
      tick(); #1;
      chk("t5_err_sticky", err_unexpected, 1);
      chk("t5_outstanding", outstanding, 0);
      do_reset();
      #1;
      chk("t5_err_cleared", err_unexpected, 0);

      // reset while master 2 is granted with one read outstanding
      bus.s_SCmdAccept = 1'b1;
      set_req(2, C_RD, 32'h600);
      tick(); #1;
      chk("t6_first_accept", bus.m_SCmdAccept, 4'b0100);
      tick();
      bus.s_SCmdAccept = 1'b0;
      set_req(2, C_RD, 32'h604);
      #1;
      chk("t6_out1", outstanding, 1);
      tick(); #1;
      chk("t6_granted_cmd", bus.s_MCmd, C_RD);
      chk("t6_granted_addr", bus.s_MAddr, 32'h604);
      reset = 1'b1;
      bus.s_SCmdAccept = 1'b1;
      set_req(0, C_RD, 32'h700);
      #1;
      chk("t6_no_accept_in_reset", bus.m_SCmdAccept, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("t6_cmd_idle", bus.s_MCmd, C_IDLE);
      chk("t6_out0", outstanding, 0);
      chk("t6_accept0", bus.m_SCmdAccept, 0);
      tick(); #1;
      chk("t6_m0_priority", bus.m_SCmdAccept, 4'b0001);
      chk("t6_m0_addr", bus.s_MAddr, 32'h700);
      tick();
      clear_all();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
